heap_feeder: RTL and testbench
==============================

// Module: heap_feeder
// PURPOSE
//   Upstream stage of the heap sorter. Takes a per-frame stream of scored features over valid/ready.
//   Packs each feature into a heap data word: {2'b00, payload, key}.
//   Sequences heap_init, rate-limited heap_en inserts, heap_flush and the drain wait, then reports frame done.
//   Sits between the feature scorer and the heap; drives the heap's din/en/init/flush pins directly.
// PARAMETERS
//   DATA_WIDTH  8  heap word width; must equal the heap's DATA_WIDTH
//   KEY_WIDTH   4  key field width; must equal the heap's KEY_WIDTH
//   NLEVELS     2  heap levels; HEAP_SIZE = 2^(NLEVELS+1)-1; used for the drain count
//   CNT_WIDTH  16  width of the per-frame insert and drop counters
// PORTS
//   clk          in   1                    single clock; all logic on posedge
//   rst          in   1                    reset: synchronous, active-high
//   frame_start  in   1                    pulse; starts a frame (honoured only in IDLE)
//   frame_end    in   1                    pulse; last beat of frame has been or is being offered
//   s_valid      in   1                    feature beat valid
//   s_ready      out  1                    feature beat accepted when s_valid & s_ready
//   s_key        in   KEY_WIDTH            sort key
//   s_payload    in   DATA_WIDTH-2-KEY_WIDTH  payload carried with key
//   heap_din     out  DATA_WIDTH           to heap din
//   heap_en      out  1                    to heap en (insert strobe)
//   heap_init    out  1                    to heap init
//   heap_flush   out  1                    to heap flush
//   busy         out  1                    high in every state except IDLE
//   done         out  1                    1-cycle pulse on DRAIN->IDLE
//   ins_cnt      out  CNT_WIDTH            inserts issued this frame; held until the next INIT
//   drop_cnt     out  CNT_WIDTH            beats filtered this frame (0 unless filter compiled in)
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-high.
//   Reset (rst=1 at posedge, including mid-frame):
//     - state=IDLE; all outputs 0; internal counters 0.
//     - Heap contents are not cleared; the next frame's INIT clears them.
//   FSM:
//     - IDLE: frame_start -> INIT.
//     - INIT: heap_init=1 for exactly 1 cycle; ins_cnt and drop_cnt cleared -> LOAD.
//     - LOAD: accept beats. end_seen is set by frame_end and held. end_seen & no accept this cycle -> GAP_END.
//     - GAP_END: 2 idle cycles, so the last insert settles in the heap -> FLUSH.
//     - FLUSH: heap_flush=1 for exactly 1 cycle -> DRAIN.
//     - DRAIN: wait 2*HEAP_SIZE+4 cycles (18 at defaults) -> IDLE with done=1.
//   s_ready = (state==LOAD) & ~end_seen & ~gap.
//     - gap is set the cycle after any accept, so inserts are spaced at least 2 cycles apart (heap pipeline constraint).
//     - Peak rate: 1 beat per 2 cycles.
//   Insert path: a beat accepted at posedge t drives heap_en=1 and heap_din={2'b00,s_payload,s_key} during cycle t+1 (registered).
//     - Otherwise heap_en=0 and heap_din holds its last value.
//   Simultaneous events:
//     - frame_end with an accepted beat in the same cycle: the beat is inserted and is the frame's last beat.
//     - frame_end outside LOAD: ignored.
//     - frame_start outside IDLE: ignored, with no effect on the frame in progress.
//     - frame_end in LOAD with no beats ever sent: the frame still runs INIT/FLUSH/DRAIN with ins_cnt=0.
//   Counters saturate at all-ones; they never wrap.
//   s_valid without s_ready: the beat must be held by the source (standard valid/ready). No beat is lost or duplicated.
// CONFIGURATION
//   HEAP_FEEDER_THRESH_EN
//     Defined:
//       - Adds input thresh [KEY_WIDTH] (sampled every cycle).
//       - A beat with s_key < thresh is still accepted (handshake unchanged, gap still applied) but not inserted: heap_en stays 0.
//       - drop_cnt increments for each such beat.
//     Undefined:
//       - No thresh port; every accepted beat is inserted; drop_cnt is tied to 0.
// TESTING
//   1. Reset, frame_start, 3 beats keys 5,2,9 with s_valid held high, frame_end with 3rd beat
//      -> heap_en pulses 2 cycles apart; heap_din = 8'h05,8'h02,8'h09 (payload 0); heap_flush 3 cycles after last heap_en; done 19 cycles after flush; ins_cnt=3.
//   2. Back-to-back s_valid with s_key=1..7 -> s_ready toggles 1,0,1,0...; exactly 7 heap_en pulses; no two adjacent.
//   3. frame_start during LOAD, and a second frame_start during DRAIN
//      -> both ignored; single done pulse; busy stays 1 throughout.
//   4. rst=1 mid-LOAD after 2 inserts
//      -> next cycle state IDLE, heap_en/heap_init/heap_flush/busy/done=0, ins_cnt=0; a new frame then starts cleanly with heap_init.
//   5. frame_start then immediate frame_end, no beats
//      -> heap_init, heap_flush, done all pulse once; ins_cnt=0.
//   6. HEAP_FEEDER_THRESH_EN, thresh=4, keys 3,4,8,1
//      -> heap_en only for keys 4 and 8; drop_cnt=2; ins_cnt=2; all 4 beats handshaken.

Source files
------------

// File: rtl/heap_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : heap_feeder                                                      |
// | Purpose : Packs scored features into heap words and sequences the heap's   |
// |           init / rate-limited insert / flush / drain phases of a frame.    |
// |           Optional key threshold filter: HEAP_FEEDER_THRESH_EN.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module heap_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int KEY_WIDTH  = 4,
    parameter int NLEVELS    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic                              frame_end,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [KEY_WIDTH-1:0]              s_key,
    input  logic [DATA_WIDTH-KEY_WIDTH-3:0]   s_payload,
`ifdef HEAP_FEEDER_THRESH_EN
    input  logic [KEY_WIDTH-1:0]              thresh,
`endif
    output logic [DATA_WIDTH-1:0]             heap_din,
    output logic                              heap_en,
    output logic                              heap_init,
    output logic                              heap_flush,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_WIDTH-1:0]              ins_cnt,
    output logic [CNT_WIDTH-1:0]              drop_cnt
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_init  = 3'd1;
    localparam logic [2:0] c_st_load  = 3'd2;
    localparam logic [2:0] c_st_gap   = 3'd3;
    localparam logic [2:0] c_st_flush = 3'd4;
    localparam logic [2:0] c_st_drain = 3'd5;

    localparam int c_heap_size    = (1 << (NLEVELS + 1)) - 1;
    localparam int c_drain_cycles = 2 * c_heap_size + 4;
    localparam int c_tw           = $clog2(c_drain_cycles + 1);
    localparam logic [c_tw-1:0] c_gap_last   = c_tw'(1);
    localparam logic [c_tw-1:0] c_drain_last = c_tw'(c_drain_cycles - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [c_tw-1:0]       r_tmr;
    logic                  r_end_seen;
    logic                  r_gap;
    logic                  r_heap_en;
    logic [DATA_WIDTH-1:0] r_heap_din;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_ins_cnt;
    logic                  w_accept;
    logic                  w_pass;

    assign s_ready    = (r_state == c_st_load) & ~r_end_seen & ~r_gap;
    assign w_accept   = s_valid & s_ready;
    assign heap_en    = r_heap_en;
    assign heap_din   = r_heap_din;
    assign heap_init  = (r_state == c_st_init);
    assign heap_flush = (r_state == c_st_flush);
    assign busy       = (r_state != c_st_idle);
    assign done       = r_done;
    assign ins_cnt    = r_ins_cnt;

`ifdef HEAP_FEEDER_THRESH_EN
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    assign w_pass   = (s_key >= thresh);
    assign drop_cnt = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (r_state == c_st_init) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_pass && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
        end
    end
`else
    assign w_pass   = 1'b1;
    assign drop_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (frame_start) w_next_state = c_st_init;
            c_st_init:  w_next_state = c_st_load;
            c_st_load:  if (r_end_seen && !w_accept) w_next_state = c_st_gap;
            c_st_gap:   if (r_tmr == c_gap_last) w_next_state = c_st_flush;
            c_st_flush: w_next_state = c_st_drain;
            c_st_drain: if (r_tmr == c_drain_last) w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // r_tmr restarts on every state change; only GAP_END and DRAIN look at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr      <= '0;
            r_end_seen <= 1'b0;
            r_gap      <= 1'b0;
            r_heap_en  <= 1'b0;
            r_heap_din <= '0;
            r_done     <= 1'b0;
            r_ins_cnt  <= '0;
        end else begin
            r_tmr     <= (w_next_state != r_state) ? '0 : r_tmr + c_tw'(1);
            r_gap     <= w_accept;
            r_heap_en <= w_accept & w_pass;
            r_done    <= (r_state == c_st_drain) && (w_next_state == c_st_idle);
            if (w_accept && w_pass) begin
                r_heap_din <= {2'b00, s_payload, s_key};
            end
            if (r_state == c_st_init) begin
                r_end_seen <= 1'b0;
                r_ins_cnt  <= '0;
            end else begin
                if ((r_state == c_st_load) && frame_end) begin
                    r_end_seen <= 1'b1;
                end
                if (w_accept && w_pass && (r_ins_cnt != '1)) begin
                    r_ins_cnt <= r_ins_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_heap_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_heap_feeder                                                   |
// | Purpose : Directed, table-driven self-checking bench for heap_feeder.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_heap_feeder;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       frame_end;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] s_key;
    logic [1:0] s_payload;
`ifdef HEAP_FEEDER_THRESH_EN
    logic [3:0] thresh;
`endif
    logic [7:0]  heap_din;
    logic        heap_en;
    logic        heap_init;
    logic        heap_flush;
    logic        busy;
    logic        done;
    logic [15:0] ins_cnt;
    logic [15:0] drop_cnt;

    heap_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_key       (s_key),
        .s_payload   (s_payload),
`ifdef HEAP_FEEDER_THRESH_EN
        .thresh      (thresh),
`endif
        .heap_din    (heap_din),
        .heap_en     (heap_en),
        .heap_init   (heap_init),
        .heap_flush  (heap_flush),
        .busy        (busy),
        .done        (done),
        .ins_cnt     (ins_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat index 0 sits in the least significant field of each packed vector.
    typedef struct packed {
        logic [3:0]      n;
        logic [7:0][3:0] key;
        logic [7:0][1:0] pay;
        logic [7:0][7:0] din;
    } frame_t;

    frame_t frames [6];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int en_cnt, init_cnt, flush_cnt, done_cnt, adj_err, busy_low;
    int last_en_cyc, flush_cyc, done_cyc;
    bit prev_en = 1'b0;
    bit track_busy = 1'b0;
    logic [7:0] din_q[$];
    bit rdy_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (heap_en) begin
            en_cnt++;
            din_q.push_back(heap_din);
            last_en_cyc = cyc;
            if (prev_en) adj_err++;
        end
        prev_en = heap_en;
        if (heap_init) init_cnt++;
        if (heap_flush) begin
            flush_cnt++;
            flush_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (track_busy && !busy && !done) busy_low++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        en_cnt = 0; init_cnt = 0; flush_cnt = 0; done_cnt = 0;
        adj_err = 0; busy_low = 0;
        last_en_cyc = 0; flush_cyc = 0; done_cyc = 0;
        din_q.delete();
        rdy_q.delete();
    endtask

    // Starts a frame, offers beats with s_valid held, pulses frame_end with the
    // last accepted beat; stops early (no frame_end) when stop_after < f.n.
    task automatic load_frame(input frame_t f, input bit fs_mid, input int stop_after);
        int i = 0;
        int guard = 0;
        bit acc;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        while (i < stop_after && guard < 200) begin
            s_valid     = 1'b1;
            s_key       = f.key[i];
            s_payload   = f.pay[i];
            rdy_q.push_back(s_ready);
            frame_end   = s_ready && (i == int'(f.n) - 1) && (stop_after == int'(f.n));
            frame_start = fs_mid && (i == 1);
            acc         = s_ready;
            step();
            frame_end   = 1'b0;
            frame_start = 1'b0;
            if (acc) i++;
            guard++;
        end
        s_valid = 1'b0;
        if (guard >= 200) check("load_timeout", 64'(i), 64'(stop_after));
        if (f.n == 4'd0) begin
            frame_end = 1'b1;
            step();
            frame_end = 1'b0;
        end
    endtask

    task automatic finish_frame();
        int g = 0;
        while (done_cnt == 0 && g < 100) begin
            step();
            g++;
        end
        if (done_cnt == 0) check("done_timeout", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frames[0] = '{n: 4'd3, key: 32'h0000_0925, pay: 16'h0000, din: 64'h0000_0000_0009_0205};
        frames[1] = '{n: 4'd3, key: 32'h0000_0A0F, pay: 16'h0027, din: 64'h0000_0000_002A_103F};
        frames[2] = '{n: 4'd1, key: 32'h0000_0007, pay: 16'h0002, din: 64'h0000_0000_0000_0027};
        frames[3] = '{n: 4'd0, key: 32'h0,         pay: 16'h0000, din: 64'h0};
        frames[4] = '{n: 4'd7, key: 32'h0765_4321, pay: 16'h0000, din: 64'h0007_0605_0403_0201};
        frames[5] = '{n: 4'd4, key: 32'h0000_4321, pay: 16'h00E4, din: 64'h0000_0000_3423_1201};

        rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0;
        s_valid = 1'b0; s_key = '0; s_payload = '0;
`ifdef HEAP_FEEDER_THRESH_EN
        thresh = 4'd0;
`endif
        repeat (3) step();
        check("reset_outputs",
              {heap_en, heap_init, heap_flush, busy, done, s_ready, heap_din, ins_cnt, drop_cnt}, 64'd0);
        rst = 1'b0;
        step();
        check("idle_after_reset", {busy, s_ready, heap_init}, 64'd0);

        // Table of complete frames.
        for (int k = 0; k < 6; k++) begin
            clear_mon();
            load_frame(frames[k], 1'b0, int'(frames[k].n));
            finish_frame();
            check($sformatf("f%0d_en_cnt", k), 64'(en_cnt), 64'(frames[k].n));
            check($sformatf("f%0d_adjacent_en", k), 64'(adj_err), 64'd0);
            check($sformatf("f%0d_init_cnt", k), 64'(init_cnt), 64'd1);
            check($sformatf("f%0d_flush_cnt", k), 64'(flush_cnt), 64'd1);
            check($sformatf("f%0d_done_cnt", k), 64'(done_cnt), 64'd1);
            check($sformatf("f%0d_done_lat", k), 64'(done_cyc - flush_cyc), 64'd19);
            check($sformatf("f%0d_ins_cnt", k), 64'(ins_cnt), 64'(frames[k].n));
            check($sformatf("f%0d_drop_cnt", k), 64'(drop_cnt), 64'd0);
            check($sformatf("f%0d_busy_end", k), 64'(busy), 64'd0);
            check($sformatf("f%0d_din_count", k), 64'(din_q.size()), 64'(frames[k].n));
            for (int j = 0; j < int'(frames[k].n); j++) begin
                if (j < din_q.size())
                    check($sformatf("f%0d_din%0d", k, j), 64'(din_q[j]), 64'(frames[k].din[j]));
            end
            if (frames[k].n != 4'd0) begin
                int mism = 0;
                check($sformatf("f%0d_flush_lat", k), 64'(flush_cyc - last_en_cyc), 64'd3);
                check($sformatf("f%0d_ready_len", k), 64'(rdy_q.size()), 64'(2 * int'(frames[k].n) - 1));
                foreach (rdy_q[j]) if (rdy_q[j] != ((j % 2) == 0)) mism++;
                check($sformatf("f%0d_ready_alt", k), 64'(mism), 64'd0);
            end
            repeat (2) step();
        end

        // frame_start during LOAD and during DRAIN is ignored.
        clear_mon();
        track_busy = 1'b1;
        load_frame(frames[0], 1'b1, 3);
        begin
            int g = 0;
            while (flush_cnt == 0 && g < 50) begin
                step();
                g++;
            end
        end
        repeat (5) step();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("ign_busy_in_drain", 64'(busy), 64'd1);
        finish_frame();
        track_busy = 1'b0;
        check("ign_busy_low", 64'(busy_low), 64'd0);
        check("ign_en_cnt", 64'(en_cnt), 64'd3);
        repeat (30) step();
        check("ign_done_cnt", 64'(done_cnt), 64'd1);
        check("ign_init_cnt", 64'(init_cnt), 64'd1);
        check("ign_idle", 64'(busy), 64'd0);

        // Reset in the middle of LOAD after two inserts.
        clear_mon();
        load_frame(frames[4], 1'b0, 2);
        check("mid_ins_cnt", 64'(ins_cnt), 64'd2);
        check("mid_heap_en", 64'(heap_en), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outputs", {heap_en, heap_init, heap_flush, busy, done, s_ready}, 64'd0);
        check("rst_ins_cnt", 64'(ins_cnt), 64'd0);
        clear_mon();
        load_frame(frames[0], 1'b0, 3);
        finish_frame();
        check("post_rst_init", 64'(init_cnt), 64'd1);
        check("post_rst_en_cnt", 64'(en_cnt), 64'd3);
        check("post_rst_ins_cnt", 64'(ins_cnt), 64'd3);
        check("post_rst_done", 64'(done_cnt), 64'd1);

`ifdef HEAP_FEEDER_THRESH_EN
        begin
            frame_t ft;
            ft = '{n: 4'd4, key: 32'h0000_1843, pay: 16'h0000, din: 64'h0};
            repeat (2) step();
            thresh = 4'd4;
            clear_mon();
            load_frame(ft, 1'b0, 4);
            finish_frame();
            check("thr_en_cnt", 64'(en_cnt), 64'd2);
            check("thr_din_count", 64'(din_q.size()), 64'd2);
            if (din_q.size() >= 2) begin
                check("thr_din0", 64'(din_q[0]), 64'h04);
                check("thr_din1", 64'(din_q[1]), 64'h08);
            end
            check("thr_drop_cnt", 64'(drop_cnt), 64'd2);
            check("thr_ins_cnt", 64'(ins_cnt), 64'd2);
            check("thr_handshakes", 64'(rdy_q.size()), 64'd7);
            thresh = 4'd0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
